wb_trap_ctrl: RTL and testbench
===============================

Name: wb_trap_ctrl

Overview:
- Trap and interrupt sequencer for the Write Back stage of the veriRISCV core.
- Samples the interrupt lines and the retiring instruction in WB, and decides when a trap or mret is taken.
- Kills the WB register write, issues CSR update strobes, and drives a handshaked PC redirect to fetch.
- Holds off further traps until the pipeline has refilled.

Parameters:
- XLEN, 32, data/PC width.
- DRAIN_CYCLES, 3, cycles after redirect acceptance during which no new trap is taken (range 1..15).
- DEBUG_ADDR, 32'h0000_0800, debug entry PC; used only with the optional feature.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- software_interrupt  in  1  level, machine software interrupt pending
- timer_interrupt  in  1  level, machine timer interrupt pending
- external_interrupt  in  1  level, machine external interrupt pending
- debug_interrupt  in  1  level, debug request; used only with the optional feature
- wb_valid  in  1  a valid instruction occupies WB this cycle
- wb_pc  in  XLEN  PC of the WB instruction
- wb_exception  in  1  WB instruction raised a synchronous exception
- wb_exc_cause  in  4  exception code
- wb_exc_tval  in  XLEN  exception trap value
- wb_mret  in  1  WB instruction is mret
- csr_mstatus_mie  in  1  global interrupt enable
- csr_mie  in  3  enables {MEIE, MTIE, MSIE}
- csr_mtvec  in  XLEN  [XLEN-1:2] base, [1:0] mode (0 direct, 1 vectored)
- csr_mepc  in  XLEN  current mepc, used as the mret target
- wb_kill  out  1  combinational; suppress reg write/retire of the WB instruction
- trap_csr_we  out  1  one-cycle pulse: write mepc, mcause and mtval; MPIE<=MIE, MIE<=0
- trap_mepc  out  XLEN  value for mepc
- trap_mcause  out  XLEN  value for mcause; bit XLEN-1 = interrupt
- trap_mtval  out  XLEN  value for mtval
- mret_csr_we  out  1  one-cycle pulse: MIE<=MPIE, MPIE<=1
- pipe_flush  out  1  one-cycle pulse, flush IF..MEM
- redirect_valid  out  1  redirect request to fetch
- redirect_pc  out  XLEN  redirect target
- redirect_ready  in  1  fetch accepts the redirect
- busy  out  1  state != IDLE

Behaviour:
- Reset (synchronous): state=IDLE, drain counter=0. Every registered output is 0: trap_csr_we, mret_csr_we, pipe_flush, redirect_valid, redirect_pc, trap_mepc, trap_mcause, trap_mtval, busy.
- Event detection in IDLE (combinational; "event cycle" = the detecting cycle T). Priority, highest first:
  - exception: wb_valid & wb_exception.
  - interrupts, considered only when wb_valid & ~wb_exception & csr_mstatus_mie; priority among them MEI (cause 11) > MSI (3) > MTI (7), each gated by its csr_mie bit.
  - mret: wb_valid & wb_mret & no exception or interrupt taken.
- wb_kill=1 in the event cycle for trap events (the instruction does not retire) and 0 for mret (mret retires). wb_kill=0 in all non-IDLE states.
- In non-IDLE states upstream must present wb_valid=0; any wb_valid seen there is ignored.
- Registered at T+1 for a trap:
  - trap_csr_we=1, pipe_flush=1.
  - trap_mepc=wb_pc.
  - trap_mcause = {1'b0, zero-extended wb_exc_cause} for exceptions, or {1'b1, zero-extended code} for interrupts.
  - trap_mtval = wb_exc_tval for exceptions, 0 for interrupts.
  - redirect_valid=1.
  - redirect_pc = {base,2'b00}, plus 4*code when the event is an interrupt and mode==1. Mode values 2 and 3 are treated as direct.
  - state=REDIRECT.
- Registered at T+1 for mret: mret_csr_we=1, pipe_flush=1, redirect_valid=1, redirect_pc=csr_mepc sampled at T, state=REDIRECT.
- REDIRECT state:
  - redirect_valid and redirect_pc are held stable until redirect_ready=1.
  - The transfer cycle is when redirect_ready=1 while redirect_valid=1. The cycle after it: redirect_valid=0, counter=DRAIN_CYCLES, state=DRAIN.
  - If redirect_ready=1 in the very first REDIRECT cycle, transfer happens that cycle (1-cycle handshake).
- DRAIN state: counter decrements each cycle; at 1 the next state is IDLE. Interrupts asserted during REDIRECT/DRAIN stay pending and are taken at the first IDLE cycle with wb_valid=1.
- Strobes trap_csr_we, mret_csr_we and pipe_flush are exactly one cycle wide per event.
- Trap data outputs (trap_mepc, trap_mcause, trap_mtval) hold their value until the next event.
- Reset asserted in any state returns to IDLE next cycle with all outputs 0, even mid-handshake.
- Minimum trap-to-trap spacing: 2 + DRAIN_CYCLES cycles.

Optional Feature:
- Macro: WB_TRAP_DEBUG_EN.
- When defined: debug_interrupt & wb_valid is the highest-priority event, above exceptions.
  - wb_kill=1.
  - Outputs dbg_csr_we (1-bit pulse) and dpc (XLEN, =wb_pc) are added.
  - redirect_pc=DEBUG_ADDR.
  - trap_csr_we=0.
  - Internal debug_mode flag is set; while it is set, all interrupts are masked.
  - An mret while debug_mode=1 clears debug_mode and redirects to dpc instead of csr_mepc.
- When undefined: debug_interrupt is ignored; the dbg_csr_we and dpc ports and the debug_mode logic are absent.

Test Plan:
- Reset with all inputs 0, then 5 idle cycles -> all outputs 0, busy=0.
- wb_valid=1, wb_pc=0x100, wb_exception=1, cause=2, tval=0xDEAD, mtvec=0x200 -> wb_kill=1 at T. At T+1: trap_csr_we=1, mcause=0x2, mepc=0x100, mtval=0xDEAD, redirect_pc=0x200.
- MIE=1, mie=3'b111, timer and external interrupts both high, mtvec=0x201, wb_pc=0x40 -> mcause=0x8000000B, redirect_pc=0x22C, mtval=0.
- redirect_ready held 0 for 4 cycles, then 1 -> redirect_valid/redirect_pc stable for all 4 cycles. Then DRAIN lasts 3 cycles; a software interrupt raised during DRAIN is taken in the first IDLE valid cycle with mcause=0x80000003.
- wb_mret with csr_mepc=0x344 -> mret_csr_we=1 and pipe_flush=1 for 1 cycle, redirect_pc=0x344, wb_kill=0.
- rst asserted during REDIRECT -> next cycle state IDLE, redirect_valid=0, busy=0.

Source files
------------

// File: rtl/wb_trap_ctrl.sv
// Write-back trap/mret sequencer: kills the WB instruction, pulses CSR updates and hands a PC redirect to fetch.
// Optional debug entry/exit path is compiled in with `define WB_TRAP_DEBUG_EN.
module wb_trap_ctrl #(
  parameter int              XLEN         = 32,
  parameter int              DRAIN_CYCLES = 3,
  parameter logic [XLEN-1:0] DEBUG_ADDR   = 32'h0000_0800
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            software_interrupt,
  input  logic            timer_interrupt,
  input  logic            external_interrupt,
  input  logic            debug_interrupt,
  input  logic            wb_valid,
  input  logic [XLEN-1:0] wb_pc,
  input  logic            wb_exception,
  input  logic [3:0]      wb_exc_cause,
  input  logic [XLEN-1:0] wb_exc_tval,
  input  logic            wb_mret,
  input  logic            csr_mstatus_mie,
  input  logic [2:0]      csr_mie,
  input  logic [XLEN-1:0] csr_mtvec,
  input  logic [XLEN-1:0] csr_mepc,
  output logic            wb_kill,
  output logic            trap_csr_we,
  output logic [XLEN-1:0] trap_mepc,
  output logic [XLEN-1:0] trap_mcause,
  output logic [XLEN-1:0] trap_mtval,
  output logic            mret_csr_we,
  output logic            pipe_flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready,
`ifdef WB_TRAP_DEBUG_EN
  output logic            dbg_csr_we,
  output logic [XLEN-1:0] dpc,
`endif
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} state_t;

  state_t     state;
  logic [3:0] drain_cnt;
  logic       is_idle, exc_evt, irq_ok, mei, msi, mti, irq_evt, trap_evt, mret_evt, dbg_evt;
  logic [3:0] irq_code;
  logic [XLEN-1:0] mtvec_base, trap_target;

`ifdef WB_TRAP_DEBUG_EN
  logic debug_mode;
  // No nested debug entry: a request while already halted is ignored.
  assign dbg_evt = debug_interrupt & wb_valid & ~debug_mode;
  assign irq_ok  = wb_valid & ~wb_exception & csr_mstatus_mie & ~debug_mode;
`else
  logic unused_debug;
  assign unused_debug = debug_interrupt;
  assign dbg_evt      = 1'b0;
  assign irq_ok       = wb_valid & ~wb_exception & csr_mstatus_mie;
`endif

  assign is_idle  = (state == IDLE);
  assign exc_evt  = wb_valid & wb_exception;
  assign mei      = external_interrupt & csr_mie[2];
  assign msi      = software_interrupt & csr_mie[0];
  assign mti      = timer_interrupt    & csr_mie[1];
  assign irq_evt  = irq_ok & (mei | msi | mti);
  assign trap_evt = dbg_evt | exc_evt | irq_evt;
  assign mret_evt = wb_valid & wb_mret & ~trap_evt;
  assign wb_kill  = is_idle & trap_evt;
  assign busy     = ~is_idle;

  always_comb begin
    irq_code = 4'd7;
    if (mei)      irq_code = 4'd11;
    else if (msi) irq_code = 4'd3;
  end

  // Vectored mode offsets only interrupts; modes 2/3 fall back to direct.
  assign mtvec_base = {csr_mtvec[XLEN-1:2], 2'b00};
  always_comb begin
    trap_target = mtvec_base;
    if (!exc_evt && csr_mtvec[1:0] == 2'b01)
      trap_target = mtvec_base + {{(XLEN-6){1'b0}}, irq_code, 2'b00};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      drain_cnt      <= '0;
      trap_csr_we    <= 1'b0;
      mret_csr_we    <= 1'b0;
      pipe_flush     <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      trap_mepc      <= '0;
      trap_mcause    <= '0;
      trap_mtval     <= '0;
`ifdef WB_TRAP_DEBUG_EN
      dbg_csr_we     <= 1'b0;
      dpc            <= '0;
      debug_mode     <= 1'b0;
`endif
    end else begin
      trap_csr_we <= 1'b0;
      mret_csr_we <= 1'b0;
      pipe_flush  <= 1'b0;
`ifdef WB_TRAP_DEBUG_EN
      dbg_csr_we  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (dbg_evt) begin
`ifdef WB_TRAP_DEBUG_EN
            dbg_csr_we     <= 1'b1;
            dpc            <= wb_pc;
            debug_mode     <= 1'b1;
`endif
            pipe_flush     <= 1'b1;
            redirect_valid <= 1'b1;
            redirect_pc    <= DEBUG_ADDR;
            state          <= REDIRECT;
          end else if (trap_evt) begin
            trap_csr_we    <= 1'b1;
            pipe_flush     <= 1'b1;
            trap_mepc      <= wb_pc;
            trap_mcause    <= exc_evt ? {1'b0, {(XLEN-5){1'b0}}, wb_exc_cause}
                                      : {1'b1, {(XLEN-5){1'b0}}, irq_code};
            trap_mtval     <= exc_evt ? wb_exc_tval : '0;
            redirect_valid <= 1'b1;
            redirect_pc    <= trap_target;
            state          <= REDIRECT;
          end else if (mret_evt) begin
            mret_csr_we    <= 1'b1;
            pipe_flush     <= 1'b1;
            redirect_valid <= 1'b1;
`ifdef WB_TRAP_DEBUG_EN
            redirect_pc    <= debug_mode ? dpc : csr_mepc;
            debug_mode     <= 1'b0;
`else
            redirect_pc    <= csr_mepc;
`endif
            state          <= REDIRECT;
          end
        end
        REDIRECT: begin
          if (redirect_ready) begin
            redirect_valid <= 1'b0;
            drain_cnt      <= 4'(DRAIN_CYCLES);
            state          <= DRAIN;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt - 4'd1;
          if (drain_cnt == 4'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_trap_ctrl.sv
// Directed bench for wb_trap_ctrl: cycle-stamp model of trap/redirect/drain timing plus literal spot checks.
module tb_wb_trap_ctrl;
  localparam int XLEN = 32;
  localparam int D    = 3;
  localparam longint NEVER = 64'h7fff_ffff_ffff_ffff;

  logic clk = 1'b0;
  logic rst, software_interrupt, timer_interrupt, external_interrupt, debug_interrupt;
  logic wb_valid, wb_exception, wb_mret, csr_mstatus_mie, redirect_ready;
  logic [3:0] wb_exc_cause;
  logic [2:0] csr_mie;
  logic [31:0] wb_pc, wb_exc_tval, csr_mtvec, csr_mepc;
  logic wb_kill, trap_csr_we, mret_csr_we, pipe_flush, redirect_valid, busy;
  logic [31:0] trap_mepc, trap_mcause, trap_mtval, redirect_pc;
`ifdef WB_TRAP_DEBUG_EN
  logic dbg_csr_we;
  logic [31:0] dpc;
`endif

  always #5 clk = ~clk;

  wb_trap_ctrl #(.XLEN(XLEN), .DRAIN_CYCLES(D)) dut (
    .clk(clk), .rst(rst),
    .software_interrupt(software_interrupt), .timer_interrupt(timer_interrupt),
    .external_interrupt(external_interrupt), .debug_interrupt(debug_interrupt),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_exception(wb_exception),
    .wb_exc_cause(wb_exc_cause), .wb_exc_tval(wb_exc_tval), .wb_mret(wb_mret),
    .csr_mstatus_mie(csr_mstatus_mie), .csr_mie(csr_mie), .csr_mtvec(csr_mtvec),
    .csr_mepc(csr_mepc), .wb_kill(wb_kill), .trap_csr_we(trap_csr_we),
    .trap_mepc(trap_mepc), .trap_mcause(trap_mcause), .trap_mtval(trap_mtval),
    .mret_csr_we(mret_csr_we), .pipe_flush(pipe_flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready),
`ifdef WB_TRAP_DEBUG_EN
    .dbg_csr_we(dbg_csr_we), .dpc(dpc),
`endif
    .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: events are accepted only from cycle m_free onward; an event pushes
  // m_free out to "never" until fetch accepts, then to accept+1+D.
  longint cyc = 0;
  longint m_free = 0;
  logic m_tcwe = 0, m_mcwe = 0, m_flush = 0, m_rv = 0;
  logic [31:0] m_rpc = 0, m_mepc = 0, m_mcause = 0, m_mtval = 0;

  function automatic int irq_code_f();
    if (external_interrupt && csr_mie[2]) return 11;
    if (software_interrupt && csr_mie[0]) return 3;
    if (timer_interrupt && csr_mie[1])    return 7;
    return 0;
  endfunction

  // 0 none, 1 exception, 2 interrupt, 3 mret
  function automatic int ev_kind();
    if (!wb_valid)                           return 0;
    if (wb_exception)                        return 1;
    if (csr_mstatus_mie && irq_code_f() != 0) return 2;
    if (wb_mret)                             return 3;
    return 0;
  endfunction

  function automatic logic [31:0] vec_target();
    logic [31:0] base;
    base = csr_mtvec & 32'hFFFF_FFFC;
    if (csr_mtvec[1:0] == 2'b01) return base + 32'(4 * irq_code_f());
    return base;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_tcwe <= 0; m_mcwe <= 0; m_flush <= 0; m_rv <= 0;
      m_rpc <= 0; m_mepc <= 0; m_mcause <= 0; m_mtval <= 0;
      m_free <= 0;
    end else begin
      m_tcwe <= 0; m_mcwe <= 0; m_flush <= 0;
      if (cyc >= m_free) begin
        case (ev_kind())
          1: begin
            m_tcwe <= 1; m_flush <= 1; m_rv <= 1; m_free <= NEVER;
            m_mepc <= wb_pc; m_mcause <= {28'b0, wb_exc_cause}; m_mtval <= wb_exc_tval;
            m_rpc <= csr_mtvec & 32'hFFFF_FFFC;
          end
          2: begin
            m_tcwe <= 1; m_flush <= 1; m_rv <= 1; m_free <= NEVER;
            m_mepc <= wb_pc; m_mcause <= 32'h8000_0000 | 32'(irq_code_f()); m_mtval <= 0;
            m_rpc <= vec_target();
          end
          3: begin
            m_mcwe <= 1; m_flush <= 1; m_rv <= 1; m_free <= NEVER;
            m_rpc <= csr_mepc;
          end
          default: ;
        endcase
      end else if (m_rv && redirect_ready) begin
        m_rv <= 0;
        m_free <= cyc + 1 + D;
      end
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("wb_kill", {31'b0, wb_kill},
          {31'b0, (cyc >= m_free) && (ev_kind() == 1 || ev_kind() == 2)});
      chk("trap_csr_we", {31'b0, trap_csr_we}, {31'b0, m_tcwe});
      chk("mret_csr_we", {31'b0, mret_csr_we}, {31'b0, m_mcwe});
      chk("pipe_flush", {31'b0, pipe_flush}, {31'b0, m_flush});
      chk("redirect_valid", {31'b0, redirect_valid}, {31'b0, m_rv});
      if (m_rv) chk("redirect_pc", redirect_pc, m_rpc);
      chk("trap_mepc", trap_mepc, m_mepc);
      chk("trap_mcause", trap_mcause, m_mcause);
      chk("trap_mtval", trap_mtval, m_mtval);
      chk("busy", {31'b0, busy}, {31'b0, !(cyc >= m_free)});
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    wb_valid = 0; wb_exception = 0; wb_mret = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 40) begin step(); n++; end
    if (n >= 40) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy still %b after %0d cycles", busy, n);
    end
  endtask

  task automatic ev(input logic v, input logic exc, input logic [3:0] cause, input logic mret,
                    input logic [2:0] irqs, input logic mst, input logic [31:0] mtvec,
                    input logic [31:0] pc);
    wb_valid = v; wb_exception = exc; wb_exc_cause = cause; wb_exc_tval = pc ^ 32'h5A5A;
    wb_mret = mret; {external_interrupt, timer_interrupt, software_interrupt} = irqs;
    csr_mstatus_mie = mst; csr_mtvec = mtvec; wb_pc = pc;
    step(); clr();
    {external_interrupt, timer_interrupt, software_interrupt} = 3'b000;
    step(); wait_idle(); step();
  endtask

  initial begin
    int n;
    rst = 1; software_interrupt = 0; timer_interrupt = 0; external_interrupt = 0;
    debug_interrupt = 0; wb_valid = 0; wb_exception = 0; wb_mret = 0; wb_pc = 0;
    wb_exc_cause = 0; wb_exc_tval = 0; csr_mstatus_mie = 0; csr_mie = 0; csr_mtvec = 0;
    csr_mepc = 0; redirect_ready = 1;
    repeat (2) step();
    rst = 0;
    repeat (5) step();
    @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_rv", {31'b0, redirect_valid}, 32'd0);
    chk("reset_mcause", trap_mcause, 32'd0);

    // Exception, direct mtvec
    step();
    wb_valid = 1; wb_pc = 32'h100; wb_exception = 1; wb_exc_cause = 4'd2;
    wb_exc_tval = 32'hDEAD; csr_mtvec = 32'h200;
    @(negedge clk);
    chk("exc_kill", {31'b0, wb_kill}, 32'd1);
    step(); clr();
    @(negedge clk);
    chk("exc_we", {31'b0, trap_csr_we}, 32'd1);
    chk("exc_mcause", trap_mcause, 32'h2);
    chk("exc_mepc", trap_mepc, 32'h100);
    chk("exc_mtval", trap_mtval, 32'hDEAD);
    chk("exc_rpc", redirect_pc, 32'h200);
    step(); wait_idle(); step();

    // MEI beats MTI, vectored; slow fetch handshake
    redirect_ready = 0; csr_mstatus_mie = 1; csr_mie = 3'b111; csr_mtvec = 32'h201;
    timer_interrupt = 1; external_interrupt = 1; wb_valid = 1; wb_pc = 32'h40;
    step(); clr(); timer_interrupt = 0; external_interrupt = 0;
    @(negedge clk);
    chk("irq_mcause", trap_mcause, 32'h8000_000B);
    chk("irq_rpc", redirect_pc, 32'h22C);
    chk("irq_mtval", trap_mtval, 32'h0);
    repeat (4) step();
    redirect_ready = 1;
    step(); redirect_ready = 0; software_interrupt = 1;
    @(negedge clk);
    n = 0;
    while (busy === 1'b1 && n < 20) begin n++; step(); @(negedge clk); end
    chk("drain_len", 32'(n), 32'd3);
    redirect_ready = 1;
    step();
    wb_valid = 1; wb_pc = 32'h80;
    step(); clr(); software_interrupt = 0;
    @(negedge clk);
    chk("msi_mcause", trap_mcause, 32'h8000_0003);
    chk("msi_rpc", redirect_pc, 32'h20C);
    step(); wait_idle(); step();

    // mret
    csr_mepc = 32'h344; wb_valid = 1; wb_mret = 1; wb_pc = 32'h90;
    @(negedge clk);
    chk("mret_kill", {31'b0, wb_kill}, 32'd0);
    step(); clr();
    @(negedge clk);
    chk("mret_we", {31'b0, mret_csr_we}, 32'd1);
    chk("mret_flush", {31'b0, pipe_flush}, 32'd1);
    chk("mret_rpc", redirect_pc, 32'h344);
    step();
    @(negedge clk);
    chk("mret_we_pulse", {31'b0, mret_csr_we}, 32'd0);
    wait_idle(); step();

    // Priority, masking and mtvec-mode corner vectors
    ev(1, 1, 4'd5, 1, 3'b111, 1, 32'h201, 32'h1000);  // exception over irq/mret
    ev(1, 0, 4'd0, 0, 3'b111, 0, 32'h201, 32'h1004);  // global MIE off: nothing
    csr_mie = 3'b010;
    ev(1, 0, 4'd0, 0, 3'b110, 1, 32'h301, 32'h1008);  // MEI masked -> MTI vectored
    csr_mie = 3'b111;
    ev(1, 0, 4'd0, 0, 3'b100, 1, 32'h402, 32'h100C);  // mode 2 = direct
    ev(1, 1, 4'd7, 0, 3'b000, 1, 32'h503, 32'h1010);  // mode 3 exception
    ev(0, 1, 4'd4, 1, 3'b111, 1, 32'h201, 32'h1014);  // no valid: nothing
    ev(1, 0, 4'd0, 1, 3'b000, 1, 32'h201, 32'h1018);  // mret

    // Reset mid-handshake
    redirect_ready = 0;
    wb_valid = 1; wb_exception = 1; wb_exc_cause = 4'd1; wb_pc = 32'h2000;
    step(); clr();
    step(); rst = 1;
    step(); rst = 0;
    @(negedge clk);
    chk("rst_rv", {31'b0, redirect_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_mcause", trap_mcause, 32'd0);
    redirect_ready = 1;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
